inst_mem_responder: RTL and testbench
=====================================

INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 Parameter DEPTH, 256, number of 16-bit instruction words stored; power of two, at most 65536.
REQ-002 Parameter NOP_WORD, 16'h0000, word returned whenever a fetch is not served from storage.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port to_mem_addr  input  16  fetch word address from the fetch stage.
REQ-006 Port from_mem_data  output  16  instruction word for to_mem_addr.
REQ-007 Port mem_stall  output  1  high while fetched data is not valid (load in progress).
REQ-008 Port load_start  input  1  request to begin a program load.
REQ-009 Port load_base  input  16  first word address of the load, sampled with load_start.
REQ-010 Port load_valid  input  1  load_data holds a word to write.
REQ-011 Port load_data  input  16  program word to write.
REQ-012 Port load_last  input  1  qualifies the final word of the load.
REQ-013 Port load_ready  output  1  responder accepts a word this cycle.
REQ-014 Port load_done  output  1  one-cycle pulse at load completion.
REQ-015 Port addr_err  output  1  sticky error flag.

Function
REQ-016 FSM states: IDLE, LOAD, DONE; reset state IDLE.
REQ-017 IDLE: from_mem_data SHALL be combinational mem[to_mem_addr] when to_mem_addr < DEPTH, else NOP_WORD; the fetch stage captures it on the same edge.
REQ-018 IDLE, to_mem_addr >= DEPTH: return NOP_WORD and set addr_err on the next edge.
REQ-019 IDLE and load_start=1: capture load_base into a 16-bit write pointer; go to LOAD if load_base < DEPTH, else set addr_err and go to DONE.
REQ-020 LOAD: load_ready=1, mem_stall=1, from_mem_data=NOP_WORD regardless of address.
REQ-021 LOAD, load_valid=1: write load_data to mem[ptr] at the edge and increment ptr.
REQ-022 LOAD, accepted word with load_last=1 or ptr=DEPTH-1: go to DONE after that write.
REQ-023 LOAD, ptr=DEPTH-1 accepted without load_last: set addr_err (overflow); no write beyond DEPTH-1 and no wrap to 0.
REQ-024 load_start while in LOAD or DONE SHALL be ignored.
REQ-025 DONE: load_done=1 and mem_stall=1 for exactly one cycle, then go to IDLE.
REQ-026 A write and a fetch to the same address in the same cycle are not possible, because fetch is masked in LOAD; the first IDLE cycle after DONE returns the new contents.
REQ-027 load_ready SHALL be 0 in IDLE and DONE; load_valid is ignored there.

Reset
REQ-028 rst=1 SHALL force: state IDLE, ptr 0, load_ready 0, load_done 0, mem_stall 0, addr_err 0.
REQ-029 Storage array SHALL NOT be reset and its contents are retained across rst. Simulation start contents are all NOP_WORD.
REQ-030 rst asserted mid-LOAD SHALL abort the load. Words already written stay written, and no load_done pulse is generated.

Structure
REQ-031 The shared package SHALL hold the 16-bit word width, NOP_WORD, and the FSM state enumeration; the fetch stage uses the same width constant.
REQ-032 A single sub-module, inst_mem_array, SHALL implement the DEPTHx16 array with one combinational read port and one synchronous write port; the FSM, pointer and flags live in inst_mem_responder.

Verification
REQ-033 Load base 0, words 16'h1111,16'h2222,16'h3333 (last on third) -> load_ready high for 3 cycles, load_done pulses once, then addr 1 reads 16'h2222.
REQ-034 Fetch addr 16'h0100 with DEPTH=256 -> from_mem_data 16'h0000, addr_err 1 next cycle and stays 1.
REQ-035 Load base 254, three words without load_last -> writes at 254 and 255 only, addr_err 1, DONE after the second word, mem[0] unchanged.
REQ-036 load_valid low for 5 cycles mid-load -> ptr holds, mem_stall stays 1, from_mem_data 16'h0000 throughout.
REQ-037 rst pulsed after two of four words -> IDLE, no load_done, first two words readable, mem_stall 0.
REQ-038 load_start with load_base 16'hFFFF -> no writes, addr_err 1, load_done pulse next cycle, back to IDLE.

Source files
------------

// File: rtl/inst_mem_responder_pkg.sv
// rtl/inst_mem_responder_pkg.sv - shared widths, default fill word and FSM states
package inst_mem_responder_pkg;
   localparam int WORD_W = 16;
   localparam int ADDR_W = 16;
   localparam logic [WORD_W-1:0] DEFAULT_NOP_WORD = 16'h0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;
endpackage

// File: rtl/inst_mem_array.sv
// rtl/inst_mem_array.sv - DEPTHx16 instruction store, async read, sync write, no reset
module inst_mem_array
   import inst_mem_responder_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW = $clog2(DEPTH),
   parameter logic [WORD_W-1:0] INIT_WORD = DEFAULT_NOP_WORD
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [WORD_W-1:0] rdata_o
);
   // Contents survive rst; the initializer only sets power-up state.
   logic [WORD_W-1:0] mem_q [DEPTH] = '{default: INIT_WORD};

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - instruction fetch responder with streamed program load
module inst_mem_responder
   import inst_mem_responder_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter logic [WORD_W-1:0] NOP_WORD = DEFAULT_NOP_WORD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] to_mem_addr,
   output logic [WORD_W-1:0] from_mem_data,
   output logic              mem_stall,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic              load_valid,
   input  logic [WORD_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              load_done,
   output logic              addr_err
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] ptr_d;
   logic              load_ready_q;
   logic              load_done_q;
   logic              mem_stall_q;
   logic              addr_err_q;

   logic              fetch_in_range;
   logic              base_in_range;
   logic              wr_en;
   logic              ptr_at_last;
   logic              last_accept;
   logic [WORD_W-1:0] rd_data;

   assign fetch_in_range = {1'b0, to_mem_addr} < DEPTH_EXT;
   assign base_in_range  = {1'b0, load_base} < DEPTH_EXT;
   assign wr_en          = (state_q == ST_LOAD) && load_valid;
   assign ptr_at_last    = (ptr_q == LAST_ADDR);
   assign last_accept    = wr_en && (load_last || ptr_at_last);
   // Pointer parks on the last slot so it can never wrap back to 0.
   assign ptr_d          = ptr_at_last ? ptr_q : ptr_q + 16'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         load_ready_q <= 1'b0;
         load_done_q  <= 1'b0;
         mem_stall_q  <= 1'b0;
         addr_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!fetch_in_range) begin
                  addr_err_q <= 1'b1;
               end
               if (load_start) begin
                  ptr_q       <= load_base;
                  mem_stall_q <= 1'b1;
                  if (base_in_range) begin
                     state_q      <= ST_LOAD;
                     load_ready_q <= 1'b1;
                  end else begin
                     state_q     <= ST_DONE;
                     load_done_q <= 1'b1;
                     addr_err_q  <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (wr_en) begin
                  ptr_q <= ptr_d;
                  if (ptr_at_last && !load_last) begin
                     addr_err_q <= 1'b1;
                  end
                  if (last_accept) begin
                     state_q      <= ST_DONE;
                     load_ready_q <= 1'b0;
                     load_done_q  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_q     <= ST_IDLE;
               load_done_q <= 1'b0;
               mem_stall_q <= 1'b0;
            end
            default: begin
               state_q      <= ST_IDLE;
               load_ready_q <= 1'b0;
               load_done_q  <= 1'b0;
               mem_stall_q  <= 1'b0;
            end
         endcase
      end
   end

   inst_mem_array #(
      .DEPTH     (DEPTH),
      .AW        (AW),
      .INIT_WORD (NOP_WORD)
   ) u_array (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (ptr_q[AW-1:0]),
      .wdata_i (load_data),
      .raddr_i (to_mem_addr[AW-1:0]),
      .rdata_o (rd_data)
   );

   assign from_mem_data = ((state_q == ST_IDLE) && fetch_in_range) ? rd_data : NOP_WORD;
   assign load_ready    = load_ready_q;
   assign load_done     = load_done_q;
   assign mem_stall     = mem_stall_q;
   assign addr_err      = addr_err_q;
endmodule

// File: tb/tb_inst_mem_responder.sv
// tb/tb_inst_mem_responder.sv - directed self-checking bench for inst_mem_responder
module tb_inst_mem_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] to_mem_addr = '0;
   logic [15:0] from_mem_data;
   logic        mem_stall;
   logic        load_start = 1'b0;
   logic [15:0] load_base = '0;
   logic        load_valid = 1'b0;
   logic [15:0] load_data = '0;
   logic        load_last = 1'b0;
   logic        load_ready;
   logic        load_done;
   logic        addr_err;

   int total = 0;
   int bad = 0;

   inst_mem_responder #(.DEPTH(256), .NOP_WORD(16'h0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .to_mem_addr   (to_mem_addr),
      .from_mem_data (from_mem_data),
      .mem_stall     (mem_stall),
      .load_start    (load_start),
      .load_base     (load_base),
      .load_valid    (load_valid),
      .load_data     (load_data),
      .load_last     (load_last),
      .load_ready    (load_ready),
      .load_done     (load_done),
      .addr_err      (addr_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", load_ready); end
      total++; if (load_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", load_done); end
      total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", mem_stall); end
      total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", addr_err); end
      total++; if (from_mem_data !== 16'h0000) begin bad++; $display("FAIL rst_data got=%h exp=0000", from_mem_data); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_load_basic();
      logic [15:0] w [3] = '{16'h1111, 16'h2222, 16'h3333};
      load_start = 1'b1; load_base = 16'd0;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL basic_ready%0d got=%b exp=1", i, load_ready); end
         total++; if (load_done !== 1'b0) begin bad++; $display("FAIL basic_done_early%0d got=%b exp=0", i, load_done); end
         total++; if (from_mem_data !== 16'h0000) begin bad++; $display("FAIL basic_mask%0d got=%h exp=0000", i, from_mem_data); end
         load_valid = 1'b1; load_data = w[i]; load_last = (i == 2);
         tick();
      end
      // valid in DONE must not write at the pointer (slot 3)
      load_data = 16'hBEEF; load_last = 1'b0;
      total++; if (load_done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", load_done); end
      total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_done got=%b exp=0", load_ready); end
      total++; if (mem_stall !== 1'b1) begin bad++; $display("FAIL basic_stall_done got=%b exp=1", mem_stall); end
      tick();
      load_valid = 1'b1;
      total++; if (load_done !== 1'b0) begin bad++; $display("FAIL basic_done_once got=%b exp=0", load_done); end
      total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL basic_stall_idle got=%b exp=0", mem_stall); end
      total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_idle got=%b exp=0", load_ready); end
      to_mem_addr = 16'd1;
      #1;
      total++; if (from_mem_data !== 16'h2222) begin bad++; $display("FAIL basic_rd1 got=%h exp=2222", from_mem_data); end
      tick();
      load_valid = 1'b0;
      to_mem_addr = 16'd0; #1;
      total++; if (from_mem_data !== 16'h1111) begin bad++; $display("FAIL basic_rd0 got=%h exp=1111", from_mem_data); end
      to_mem_addr = 16'd2; #1;
      total++; if (from_mem_data !== 16'h3333) begin bad++; $display("FAIL basic_rd2 got=%h exp=3333", from_mem_data); end
      to_mem_addr = 16'd3; #1;
      total++; if (from_mem_data !== 16'h0000) begin bad++; $display("FAIL basic_rd3 got=%h exp=0000", from_mem_data); end
      to_mem_addr = 16'd0;
      tick();
   endtask

   task automatic test_addr_err();
      to_mem_addr = 16'h0100;
      #1;
      total++; if (from_mem_data !== 16'h0000) begin bad++; $display("FAIL oob_data got=%h exp=0000", from_mem_data); end
      total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL oob_err_early got=%b exp=0", addr_err); end
      tick();
      total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL oob_err got=%b exp=1", addr_err); end
      to_mem_addr = 16'd0;
      tick(); tick();
      total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL oob_sticky got=%b exp=1", addr_err); end
      total++; if (from_mem_data !== 16'h1111) begin bad++; $display("FAIL oob_rd0 got=%h exp=1111", from_mem_data); end
      rst = 1'b1; tick(); rst = 1'b0; tick();
      total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL oob_clear got=%b exp=0", addr_err); end
      to_mem_addr = 16'd1; #1;
      total++; if (from_mem_data !== 16'h2222) begin bad++; $display("FAIL retain_rd1 got=%h exp=2222", from_mem_data); end
      to_mem_addr = 16'd0;
   endtask

   task automatic test_overflow();
      load_start = 1'b1; load_base = 16'd254;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1; load_data = 16'hAA01; load_last = 1'b0;
      tick();
      total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL ovf_ready got=%b exp=1", load_ready); end
      total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL ovf_err_early got=%b exp=0", addr_err); end
      load_data = 16'hAA02;
      tick();
      total++; if (load_done !== 1'b1) begin bad++; $display("FAIL ovf_done got=%b exp=1", load_done); end
      total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", addr_err); end
      load_data = 16'hAA03;
      tick();
      load_valid = 1'b0;
      total++; if (load_done !== 1'b0) begin bad++; $display("FAIL ovf_done_once got=%b exp=0", load_done); end
      to_mem_addr = 16'd254; #1;
      total++; if (from_mem_data !== 16'hAA01) begin bad++; $display("FAIL ovf_rd254 got=%h exp=aa01", from_mem_data); end
      to_mem_addr = 16'd255; #1;
      total++; if (from_mem_data !== 16'hAA02) begin bad++; $display("FAIL ovf_rd255 got=%h exp=aa02", from_mem_data); end
      to_mem_addr = 16'd0; #1;
      total++; if (from_mem_data !== 16'h1111) begin bad++; $display("FAIL ovf_rd0 got=%h exp=1111", from_mem_data); end
      rst = 1'b1; tick(); rst = 1'b0; tick();
   endtask

   task automatic test_stall();
      load_start = 1'b1; load_base = 16'd16;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1; load_data = 16'h5001;
      tick();
      load_valid = 1'b0;
      to_mem_addr = 16'd16;
      load_start = 1'b1; load_base = 16'd100;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (mem_stall !== 1'b1) begin bad++; $display("FAIL stall_hold%0d got=%b exp=1", i, mem_stall); end
         total++; if (from_mem_data !== 16'h0000) begin bad++; $display("FAIL stall_data%0d got=%h exp=0000", i, from_mem_data); end
         tick();
      end
      load_start = 1'b0;
      load_valid = 1'b1; load_data = 16'h5002; load_last = 1'b1;
      tick();
      load_valid = 1'b0; load_last = 1'b0;
      total++; if (load_done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b exp=1", load_done); end
      tick();
      #1;
      total++; if (from_mem_data !== 16'h5001) begin bad++; $display("FAIL stall_rd16 got=%h exp=5001", from_mem_data); end
      to_mem_addr = 16'd17; #1;
      total++; if (from_mem_data !== 16'h5002) begin bad++; $display("FAIL stall_rd17 got=%h exp=5002", from_mem_data); end
      to_mem_addr = 16'd18; #1;
      total++; if (from_mem_data !== 16'h0000) begin bad++; $display("FAIL stall_rd18 got=%h exp=0000", from_mem_data); end
      to_mem_addr = 16'd100; #1;
      total++; if (from_mem_data !== 16'h0000) begin bad++; $display("FAIL stall_rd100 got=%h exp=0000", from_mem_data); end
      to_mem_addr = 16'd0;
      tick();
   endtask

   task automatic test_reset_mid_load();
      load_start = 1'b1; load_base = 16'd32;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1; load_data = 16'h6001;
      tick();
      load_data = 16'h6002;
      tick();
      load_valid = 1'b0;
      rst = 1'b1;
      #1;
      total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b exp=0", load_ready); end
      total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL abort_stall got=%b exp=0", mem_stall); end
      tick();
      rst = 1'b0;
      tick();
      total++; if (load_done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", load_done); end
      total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL abort_stall_idle got=%b exp=0", mem_stall); end
      to_mem_addr = 16'd32; #1;
      total++; if (from_mem_data !== 16'h6001) begin bad++; $display("FAIL abort_rd32 got=%h exp=6001", from_mem_data); end
      to_mem_addr = 16'd33; #1;
      total++; if (from_mem_data !== 16'h6002) begin bad++; $display("FAIL abort_rd33 got=%h exp=6002", from_mem_data); end
      to_mem_addr = 16'd34; #1;
      total++; if (from_mem_data !== 16'h0000) begin bad++; $display("FAIL abort_rd34 got=%h exp=0000", from_mem_data); end
      to_mem_addr = 16'd0;
      tick();
   endtask

   task automatic test_bad_base();
      total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL badbase_pre got=%b exp=0", addr_err); end
      load_start = 1'b1; load_base = 16'hFFFF;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1; load_data = 16'hDEAD;
      total++; if (load_done !== 1'b1) begin bad++; $display("FAIL badbase_done got=%b exp=1", load_done); end
      total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL badbase_err got=%b exp=1", addr_err); end
      total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL badbase_ready got=%b exp=0", load_ready); end
      total++; if (mem_stall !== 1'b1) begin bad++; $display("FAIL badbase_stall got=%b exp=1", mem_stall); end
      tick();
      load_valid = 1'b0;
      total++; if (load_done !== 1'b0) begin bad++; $display("FAIL badbase_done_once got=%b exp=0", load_done); end
      total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL badbase_idle got=%b exp=0", mem_stall); end
      to_mem_addr = 16'd255; #1;
      total++; if (from_mem_data !== 16'hAA02) begin bad++; $display("FAIL badbase_rd255 got=%h exp=aa02", from_mem_data); end
      to_mem_addr = 16'd0; #1;
      total++; if (from_mem_data !== 16'h1111) begin bad++; $display("FAIL badbase_rd0 got=%h exp=1111", from_mem_data); end
      tick();
   endtask

   initial begin
      test_reset();
      test_load_basic();
      test_addr_err();
      test_overflow();
      test_stall();
      test_reset_mid_load();
      test_bad_base();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
